// File: rtl/route_elastic_buffer_if.sv
// Valid/ready word stream between a routing switch output and the next PE/switch input.
// The buffer uses the slave modport; the upstream/downstream environment uses master.
interface route_elastic_buffer_if #(
  parameter int unsigned size = 32
);
  logic [size-1:0] in0;
  logic            in_valid;
  logic            in_ready;
  logic [size-1:0] out0;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output in0, in_valid, out_ready,
    input  in_ready, out0, out_valid
  );

  modport slave (
    input  in0, in_valid, out_ready,
    output in_ready, out0, out_valid
  );
endinterface

// File: rtl/route_elastic_buffer.sv
// Config-chain programmable elastic buffer: bypass, pipeline register, FIFO or sink.
// Optional macro ROUTE_BUF_COUNT_EN adds the occupancy port 'count'.
module route_elastic_buffer #(
  parameter int unsigned size  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       config_en,
  input  logic                       config_in,
  output logic                       config_out,
  route_elastic_buffer_if.slave      bus
`ifdef ROUTE_BUF_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0]     count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_REG    = 2'd1,
    MODE_FIFO   = 2'd2,
    MODE_SINK   = 2'd3
  } mode_e;

  logic [1:0]      r_cfg;
  logic [size-1:0] r_reg_data;
  logic            r_reg_valid;
  logic [size-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_cnt;

  mode_e           w_mode;
  logic            w_in_xfer;
  logic            w_out_xfer;

  assign w_mode     = mode_e'(r_cfg);
  assign config_out = r_cfg[1];
  assign w_in_xfer  = bus.in_valid  & bus.in_ready;
  assign w_out_xfer = bus.out_valid & bus.out_ready;

  // Handshake and data presented to both sides; everything is held off while configuring.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out0      = '0;
    if (!config_en) begin
      unique case (w_mode)
        MODE_BYPASS: begin
          bus.in_ready  = bus.out_ready;
          bus.out_valid = bus.in_valid;
          bus.out0      = bus.in0;
        end
        MODE_REG: begin
          bus.in_ready  = ~r_reg_valid | bus.out_ready;
          bus.out_valid = r_reg_valid;
          bus.out0      = r_reg_data;
        end
        MODE_FIFO: begin
          bus.in_ready  = (r_cnt < CW'(DEPTH));
          bus.out_valid = (r_cnt != '0);
          bus.out0      = r_mem[r_rd_ptr];
        end
        MODE_SINK: begin
          bus.in_ready  = 1'b1;
        end
        default: begin
          bus.in_ready  = 1'b0;
        end
      endcase
    end
  end

  // Config shift chain and storage; a config shift flushes any buffered words.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cfg       <= 2'b00;
      r_reg_data  <= '0;
      r_reg_valid <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (config_en) begin
      r_cfg       <= {r_cfg[0], config_in};
      r_reg_valid <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_mode == MODE_REG) begin
        if (w_in_xfer) begin
          r_reg_data  <= bus.in0;
          r_reg_valid <= 1'b1;
        end else if (w_out_xfer) begin
          r_reg_valid <= 1'b0;
        end
      end
      if (w_mode == MODE_FIFO) begin
        if (w_in_xfer) begin
          r_mem[r_wr_ptr] <= bus.in0;
          r_wr_ptr        <= r_wr_ptr + AW'(1);
        end
        if (w_out_xfer) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        unique case ({w_in_xfer, w_out_xfer})
          2'b10:   r_cnt <= r_cnt + CW'(1);
          2'b01:   r_cnt <= r_cnt - CW'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

`ifdef ROUTE_BUF_COUNT_EN
  always_comb begin
    count = '0;
    if (!config_en) begin
      if (w_mode == MODE_REG) begin
        count = CW'(r_reg_valid);
      end else if (w_mode == MODE_FIFO) begin
        count = r_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_route_elastic_buffer.sv
// Directed bench for route_elastic_buffer with a queue-based reference model checked every cycle.
module tb_route_elastic_buffer;
  localparam int unsigned SIZE  = 32;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic config_en;
  logic config_in;
  logic config_out;
`ifdef ROUTE_BUF_COUNT_EN
  logic [$clog2(DEPTH):0] count;
`endif

  route_elastic_buffer_if #(.size(SIZE)) bus ();

  route_elastic_buffer #(.size(SIZE), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .config_en  (config_en),
    .config_in  (config_in),
    .config_out (config_out),
    .bus        (bus)
`ifdef ROUTE_BUF_COUNT_EN
    ,
    .count      (count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // Reference model: mode bits plus an ordered queue of buffered words.
  logic [1:0]  m_cfg = 2'b00;
  logic [31:0] m_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_out(output logic rdy, output logic vld, output logic [31:0] dat);
    rdy = 1'b0;
    vld = 1'b0;
    dat = '0;
    if (!config_en) begin
      case (m_cfg)
        2'd0: begin
          rdy = bus.out_ready;
          vld = bus.in_valid;
          dat = bus.in0;
        end
        2'd1: begin
          vld = (m_q.size() != 0);
          if (vld) dat = m_q[0];
          rdy = (m_q.size() == 0) || bus.out_ready;
        end
        2'd2: begin
          vld = (m_q.size() != 0);
          if (vld) dat = m_q[0];
          rdy = (m_q.size() < int'(DEPTH));
        end
        default: rdy = 1'b1;
      endcase
    end
  endfunction

  always @(posedge clk) begin : model_update
    logic r, v;
    logic [31:0] d;
    model_out(r, v, d);
    if (reset) begin
      m_cfg <= 2'b00;
      m_q.delete();
    end else if (config_en) begin
      m_cfg <= {m_cfg[0], config_in};
      m_q.delete();
    end else if (m_cfg == 2'd1 || m_cfg == 2'd2) begin
      if (v && bus.out_ready) void'(m_q.pop_front());
      if (bus.in_valid && r) m_q.push_back(bus.in0);
    end
  end

  always @(negedge clk) begin : model_compare
    logic r, v;
    logic [31:0] d;
    if (chk_on) begin
      model_out(r, v, d);
      check("out_valid", 32'(bus.out_valid), 32'(v));
      check("in_ready", 32'(bus.in_ready), 32'(r));
      check("config_out", 32'(config_out), 32'(m_cfg[1]));
      if (v || (!config_en && m_cfg == 2'd3)) check("out0", bus.out0, d);
`ifdef ROUTE_BUF_COUNT_EN
      check("count", 32'(count),
            (!config_en && (m_cfg == 2'd1 || m_cfg == 2'd2)) ? 32'(m_q.size()) : 32'd0);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic ordy);
    bus.in_valid  = v;
    bus.in0       = d;
    bus.out_ready = ordy;
  endtask

  task automatic shift_cfg(input logic b0, input logic b1);
    drive(1'b0, 32'h0, 1'b0);
    config_en = 1'b1;
    config_in = b0;
    step();
    config_in = b1;
    step();
    config_en = 1'b0;
    config_in = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    config_en = 1'b0;
    config_in = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    step();
    step();
    reset  = 1'b0;
    chk_on = 1'b1;

    // Bypass after reset: combinational pass-through.
    drive(1'b1, 32'hA5A5A5A5, 1'b0);
    #2;
    check("t1_out0", bus.out0, 32'hA5A5A5A5);
    check("t1_out_valid", 32'(bus.out_valid), 32'd1);
    check("t1_in_ready", 32'(bus.in_ready), 32'd0);
    check("t1_config_out", 32'(config_out), 32'd0);
    step();

    // FIFO fill to full, then drain in order.
    shift_cfg(1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 32'(k), 1'b0);
      #2;
      check("t2_in_ready_fill", 32'(bus.in_ready), 32'd1);
      step();
    end
    drive(1'b1, 32'd5, 1'b0);
    #2;
    check("t2_in_ready_full", 32'(bus.in_ready), 32'd0);
    check("t2_out0_head", bus.out0, 32'd1);
`ifdef ROUTE_BUF_COUNT_EN
    check("t2_count_full", 32'(count), 32'd4);
`endif
    step();
    bus.out_ready = 1'b1;
    #2;
    check("t2_full_no_accept", 32'(bus.in_ready), 32'd0);
    check("t2_seq1", bus.out0, 32'd1);
    step();
    #2;
    check("t2_seq2", bus.out0, 32'd2);
    check("t2_accept5", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    #2;
    check("t2_seq3", bus.out0, 32'd3);
    step();
    #2;
    check("t2_seq4", bus.out0, 32'd4);
    step();
    #2;
    check("t2_seq5", bus.out0, 32'd5);
    step();
    #2;
    check("t2_empty", 32'(bus.out_valid), 32'd0);
    step();

    // FIFO latency: word into empty FIFO is visible one cycle later.
    drive(1'b1, 32'h10, 1'b0);
    #2;
    check("t3_not_yet", 32'(bus.out_valid), 32'd0);
    step();
    bus.in_valid = 1'b0;
    #2;
    check("t3_valid", 32'(bus.out_valid), 32'd1);
    check("t3_out0", bus.out0, 32'h10);
    step();
    bus.out_ready = 1'b1;
    step();

    // REG mode: full throughput, then stall holds data.
    shift_cfg(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(i), 1'b1);
      #2;
      check("t4_in_ready", 32'(bus.in_ready), 32'd1);
      if (i > 0) check("t4_out0", bus.out0, 32'(i - 1));
      step();
    end
    drive(1'b1, 32'd100, 1'b0);
    for (int j = 0; j < 3; j++) begin
      #2;
      check("t4_hold_out0", bus.out0, 32'd9);
      check("t4_hold_in_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    #2;
    check("t4_release", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    #2;
    check("t4_out0_100", bus.out0, 32'd100);
    step();
    #2;
    check("t4_drained", 32'(bus.out_valid), 32'd0);
    step();

    // FIFO with two words, reconfigured to SINK.
    shift_cfg(1'b1, 1'b0);
    drive(1'b1, 32'h21, 1'b0);
    step();
    drive(1'b1, 32'h22, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0);
    config_en = 1'b1;
    config_in = 1'b1;
    #2;
    check("t5_cfg_valid", 32'(bus.out_valid), 32'd0);
    check("t5_cfg_ready", 32'(bus.in_ready), 32'd0);
    check("t5_cfg_out_a", 32'(config_out), 32'd1);
    step();
    #2;
    check("t5_cfg_out_b", 32'(config_out), 32'd0);
    step();
    config_en = 1'b0;
    drive(1'b1, 32'h33, 1'b1);
    #2;
    check("t5_sink_ready", 32'(bus.in_ready), 32'd1);
    check("t5_sink_valid", 32'(bus.out_valid), 32'd0);
    check("t5_cfg_out_c", 32'(config_out), 32'd1);
    step();
    drive(1'b0, 32'h0, 1'b0);
    step();

    // Reset mid-stream in FIFO mode returns to bypass with empty storage.
    shift_cfg(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h41 + 32'(k), 1'b0);
      step();
    end
    drive(1'b1, 32'h44, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b1, 32'h77, 1'b0);
    #2;
    check("t6_bypass_valid", 32'(bus.out_valid), 32'd1);
    check("t6_bypass_out0", bus.out0, 32'h77);
    check("t6_bypass_ready", 32'(bus.in_ready), 32'd0);
`ifdef ROUTE_BUF_COUNT_EN
    check("t6_count", 32'(count), 32'd0);
`endif
    step();
    bus.in_valid = 1'b0;
    #2;
    check("t6_bypass_idle", 32'(bus.out_valid), 32'd0);
    step();

    // Mixed push/pop pattern in FIFO mode exercising pointer wrap.
    shift_cfg(1'b1, 1'b0);
    for (int i = 0; i < 48; i++) begin
      drive((i % 3) != 0, 32'h100 + 32'(i), (i % 5) < 3);
      step();
    end
    drive(1'b0, 32'h0, 1'b1);
    repeat (6) step();

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
